// File: rtl/axi_wr_burst_ctrl.sv
`default_nettype none
// axi_wr_burst_ctrl: slave-side AXI write burst walker, one SRAM-style write per W beat, one B per burst.
// Revision 1.0
module axi_wr_burst_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 8,
    parameter int LEN_W  = 4
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic [ID_W-1:0]       AWID,
    input  logic [ADDR_W-1:0]     AWADDR,
    input  logic [LEN_W-1:0]      AWLEN,
    input  logic [2:0]            AWSIZE,
    input  logic [1:0]            AWBURST,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [DATA_W-1:0]     WDATA,
    input  logic [DATA_W/8-1:0]   WSTRB,
    input  logic                  WLAST,
    input  logic                  WVALID,
    output logic                  WREADY,
    output logic [ID_W-1:0]       BID,
    output logic [1:0]            BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb
);
    localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_W / 8));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state;
    logic [ID_W-1:0]     id_q;
    logic [ADDR_W-1:0]   cur_addr;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    cnt;
    logic [2:0]          size_q;
    logic [1:0]          burst_q;
    logic                err;
    logic                fatal;

    logic                beat;
    logic                last_beat;
    logic                wrap_len_ok;
    logic                aw_fatal;
    logic [ADDR_W-1:0]   incr;
    logic [ADDR_W-1:0]   wrap_mask;
    logic [ADDR_W-1:0]   next_addr;

    assign AWREADY   = (state == IDLE);
    assign WREADY    = (state == DATA);
    assign BVALID    = (state == RESP);
    assign BID       = id_q;
    assign BRESP     = (BVALID && (err || fatal)) ? 2'b10 : 2'b00;

    assign beat      = WVALID && (state == DATA);
    assign last_beat = (cnt == len_q);

    // Fatal bursts are still drained beat by beat, only the memory strobe is suppressed.
    assign mem_we    = beat && !fatal;
    assign mem_addr  = cur_addr;
    assign mem_wdata = WDATA;
    assign mem_wstrb = WSTRB;

    assign wrap_len_ok = (AWLEN == LEN_W'(1)) || (AWLEN == LEN_W'(3)) ||
                         (AWLEN == LEN_W'(7)) || (AWLEN == LEN_W'(15));
    assign aw_fatal    = (AWBURST == 2'b11) || (AWSIZE > MAX_SIZE) ||
                         ((AWBURST == 2'b10) && !wrap_len_ok);

    always_comb begin
        incr      = ADDR_W'(1) << size_q;
        wrap_mask = ((ADDR_W'(len_q) + ADDR_W'(1)) << size_q) - ADDR_W'(1);
        next_addr = cur_addr;
        case (burst_q)
            2'b01:   next_addr = (cur_addr & ~(incr - ADDR_W'(1))) + incr;
            2'b10:   next_addr = (cur_addr & ~wrap_mask) | ((cur_addr + incr) & wrap_mask);
            default: next_addr = cur_addr;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state    <= IDLE;
            id_q     <= '0;
            cur_addr <= '0;
            len_q    <= '0;
            cnt      <= '0;
            size_q   <= '0;
            burst_q  <= '0;
            err      <= 1'b0;
            fatal    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (AWVALID) begin
                        id_q     <= AWID;
                        cur_addr <= AWADDR;
                        len_q    <= AWLEN;
                        size_q   <= AWSIZE;
                        burst_q  <= AWBURST;
                        cnt      <= '0;
                        err      <= 1'b0;
                        fatal    <= aw_fatal;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (beat) begin
                        cnt      <= cnt + LEN_W'(1);
                        cur_addr <= next_addr;
                        // The beat count, not WLAST, terminates the burst.
                        if (WLAST != last_beat)
                            err <= 1'b1;
                        if (last_beat)
                            state <= RESP;
                    end
                end
                RESP: begin
                    if (BREADY)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire
